polyvec_acc_readout: RTL and testbench



---
 rtl/kyber_pkg.sv | 33 +++
 rtl/readout_fifo2.sv | 51 +++++
 rtl/polyvec_acc_readout.sv | 125 ++++++++++++
 tb/tb_polyvec_acc_readout.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants, readout FSM state encoding and the conditional
// subtract-q normaliser used by the RAM C readout stage.
package kyber_pkg;

    localparam int unsigned KYBER_Q = 3329;
    localparam int unsigned KYBER_N = 256;
    localparam int unsigned COEFF_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        FIN
    } readout_state_e;

    // Maps a signed coefficient in (-q, 2q) into [0, q).
    function automatic logic [COEFF_W-1:0] csubq(input logic [COEFF_W-1:0] x);
        logic signed [COEFF_W:0] xs;
        logic signed [COEFF_W:0] q;
        logic signed [COEFF_W:0] r;
        xs = $signed({x[COEFF_W-1], x});
        q  = $signed((COEFF_W+1)'(KYBER_Q));
        if (xs[COEFF_W]) begin
            r = xs + q;
        end else if (xs >= q) begin
            r = xs - q;
        end else begin
            r = xs;
        end
        return r[COEFF_W-1:0];
    endfunction

endpackage

// File: rtl/readout_fifo2.sv
// Two-entry synchronous FIFO buffering RAM C words between read issue and the
// coefficient serializer. Occupancy is bounded by the producer.
module readout_fifo2
    import kyber_pkg::*;
#(
    parameter int unsigned W = 2 * kyber_pkg::COEFF_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt_q;

endmodule

// File: rtl/polyvec_acc_readout.sv
// Drains the accumulated polynomial from RAM C and streams 256 coefficients
// over valid/ready. Define POLYVEC_READOUT_CSUBQ_EN to normalise into [0,q).
module polyvec_acc_readout
    import kyber_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned COEFF_W = kyber_pkg::COEFF_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   ram_c_re,
    output logic [DEPTH-2:0]       ram_c_addr,
    input  logic [2*COEFF_W-1:0]   ram_c_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COEFF_W-1:0]     out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    readout_state_e          state;
    logic [DEPTH-2:0]        rd_ptr;
    logic                    inflight;
    logic [DEPTH-1:0]        out_idx;
    logic [2*COEFF_W-1:0]    head;
    logic [1:0]              fifo_count;
    logic                    fire;
    logic                    pop;
    logic [2:0]              occ;
    logic                    can_issue;
    logic [COEFF_W-1:0]      coeff_raw;
    logic [COEFF_W-1:0]      coeff_norm;

    readout_fifo2 #(
        .W (2 * COEFF_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data (ram_c_rdata),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != 2'd0);
    assign fire      = out_valid & out_ready;
    assign pop       = fire & out_idx[0];

    // Words buffered or on their way (issued this cycle or returning now),
    // crediting a word popped at this edge so reads sustain one coeff/cycle.
    assign occ       = {1'b0, fifo_count} + {2'b0, ram_c_re} + {2'b0, inflight}
                     - {2'b0, pop};
    assign can_issue = (occ < 3'd2);

    assign coeff_raw = out_idx[0] ? head[2*COEFF_W-1:COEFF_W] : head[COEFF_W-1:0];

`ifdef POLYVEC_READOUT_CSUBQ_EN
    assign coeff_norm = csubq(coeff_raw);
`else
    assign coeff_norm = coeff_raw;
`endif

    assign out_data = out_valid ? coeff_norm : '0;
    assign out_last = out_valid & (&out_idx);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            ram_c_re   <= 1'b0;
            ram_c_addr <= '0;
            rd_ptr     <= '0;
            inflight   <= 1'b0;
            out_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            inflight <= ram_c_re;
            ram_c_re <= 1'b0;
            done     <= 1'b0;
            if (fire) begin
                out_idx <= out_idx + 1'b1;
            end
            case (state)
                IDLE: begin
                    // Word 0 is requested on the accepting edge itself.
                    if (start) begin
                        state      <= FETCH;
                        busy       <= 1'b1;
                        ram_c_re   <= 1'b1;
                        ram_c_addr <= '0;
                        rd_ptr     <= (DEPTH-1)'(1);
                        out_idx    <= '0;
                    end
                end
                FETCH: begin
                    if (can_issue) begin
                        ram_c_re   <= 1'b1;
                        ram_c_addr <= rd_ptr;
                        rd_ptr     <= rd_ptr + 1'b1;
                        if (&rd_ptr) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fire && (&out_idx)) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_polyvec_acc_readout.sv
// Scoreboard bench for polyvec_acc_readout: RAM C model, directed drains with
// backpressure, mid-drain reset and ignored restarts.
module tb_polyvec_acc_readout;

    localparam int unsigned Q = 3329;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        ram_c_re;
    logic [6:0]  ram_c_addr;
    logic [31:0] ram_c_rdata = 32'hDEAD_BEEF;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] ram [128];
    exp_t        sb [$];
    exp_t        e;

    int n_assert = 0;
    int n_fail   = 0;
    int outs, reads, pops, dones, lasts, lat;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;

    always #5 clk = ~clk;

    polyvec_acc_readout #(
        .DEPTH   (8),
        .COEFF_W (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .ram_c_re    (ram_c_re),
        .ram_c_addr  (ram_c_addr),
        .ram_c_rdata (ram_c_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    // Read data is valid only in the cycle after the request.
    always @(posedge clk) begin
        if (ram_c_re) ram_c_rdata <= ram[ram_c_addr];
        else          ram_c_rdata <= 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] raw);
`ifdef POLYVEC_READOUT_CSUBQ_EN
        int v;
        v = int'($signed(raw));
        if (v < 0) v = v + int'(Q);
        else if (v >= int'(Q)) v = v - int'(Q);
        return v[15:0];
`else
        return raw;
`endif
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", {16'd0, out_data}, {16'd0, prev_data});
            end
            if (ram_c_re) begin
                reads++;
                check("outstanding_le2", {31'd0, (reads - pops) <= 2}, 32'd1);
            end
            if (done) dones++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $error("FAIL sb_underflow: observed=%0d expected=none", out_data);
                end else begin
                    e = sb.pop_front();
                    check("data", {16'd0, out_data}, {16'd0, e.data});
                    check("last", {31'd0, out_last}, {31'd0, e.last});
                end
                if (out_last) lasts++;
                if (outs % 2 == 1) pops++;
                outs++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic clear_counts();
        outs = 0; reads = 0; pops = 0; dones = 0; lasts = 0;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 128; i++) ram[i] = {16'(2*i+1), 16'(2*i)};
    endtask

    task automatic expect_all();
        logic [31:0] w;
        for (int i = 0; i < 128; i++) begin
            w = ram[i];
            sb.push_back('{model(w[15:0]),  (2*i)   == 255});
            sb.push_back('{model(w[31:16]), (2*i+1) == 255});
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (dones == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", {31'd0, dones > 0}, 32'd1);
    endtask

    task automatic end_checks();
        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 32'd0);
        check("out_count", outs, 32'd256);
        check("last_count", lasts, 32'd1);
        check("done_count", dones, 32'd1);
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_outs(input int target);
        int n;
        n = 0;
        while (outs < target && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_coeff", {31'd0, outs >= target}, 32'd1);
    endtask

    initial begin
        int v;
        reset_n   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check("rst_re", {31'd0, ram_c_re}, 32'd0);
        check("rst_addr", {25'd0, ram_c_addr}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {16'd0, out_data}, 32'd0);
        check("rst_last", {31'd0, out_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Ramp, ready held high: latency and full-drain length
        fill_ramp(); clear_counts(); expect_all(); out_ready = 1'b1;
        pulse_start();
        lat = 1;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("first_read", {31'd0, ram_c_re}, 32'd1);
        check("first_addr", {25'd0, ram_c_addr}, 32'd0);
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("first_valid_cycle", lat, 32'd3);
        while (!done && lat < 600) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_cycle", lat, 32'd259);
        end_checks();

        // Boundary word plus random in-range coefficients
        for (int i = 0; i < 128; i++) begin
            v = int'($urandom_range(0, 3*Q - 3)) - int'(Q - 1);
            ram[i][15:0] = v[15:0];
            v = int'($urandom_range(0, 3*Q - 3)) - int'(Q - 1);
            ram[i][31:16] = v[15:0];
        end
        ram[0] = {16'hFFFF, 16'd3329};
        clear_counts(); expect_all();
        check("model_even0", {16'd0, sb[0].data}, 32'(model(16'd3329)));
        pulse_start();
        wait_done(1000);
        end_checks();

        // Ramp under random backpressure
        fill_ramp(); clear_counts(); expect_all();
        pulse_start();
        for (int n = 0; n < 3000 && dones == 0; n++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check("rand_done_seen", {31'd0, dones > 0}, 32'd1);
        end_checks();

        // Consumer stalled for 20 cycles after start
        clear_counts(); expect_all(); out_ready = 1'b0;
        pulse_start();
        repeat (20) @(posedge clk);
        #1;
        check("stall_reads", reads, 32'd2);
        check("stall_re_low", {31'd0, ram_c_re}, 32'd0);
        check("stall_valid_hi", {31'd0, out_valid}, 32'd1);
        check("stall_coeff0", {16'd0, out_data}, 32'd0);
        out_ready = 1'b1;
        wait_done(1000);
        end_checks();

        // Reset at coefficient 100, then a fresh full drain
        clear_counts(); expect_all();
        pulse_start();
        wait_outs(100);
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("rst_mid_busy", {31'd0, busy}, 32'd0);
            check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        end
        check("rst_mid_no_done", dones, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        sb.delete(); clear_counts(); expect_all();
        pulse_start();
        wait_done(1000);
        end_checks();

        // Second start mid-drain is ignored
        clear_counts(); expect_all();
        pulse_start();
        wait_outs(50);
        pulse_start();
        wait_done(1000);
        end_checks();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
